// File: rtl/data_mem_mmio_bridge.sv
// Data-side bridge for the single-cycle core: word RAM at low addresses,
// with a TX FIFO, a status word and an RX mailbox in the top four words.
module data_mem_mmio_bridge #(
    parameter int NUM_RAM_ADDRESS = 256,
    parameter int TX_DEPTH        = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cpu_enable,
    input  logic [$clog2(NUM_RAM_ADDRESS)-1:0] ram_address,
    input  logic [31:0]                        ram_data_write_in,
    input  logic                               ram_enable,
    input  logic                               ram_read_write,
    output logic [31:0]                        ram_data_read_out,
    output logic                               cpu_stall,
    output logic [31:0]                        tx_data,
    output logic                               tx_valid,
    input  logic                               tx_ready,
    input  logic [31:0]                        rx_data,
    input  logic                               rx_valid,
    output logic                               rx_ready
);

    localparam int AW        = $clog2(NUM_RAM_ADDRESS);
    localparam int CW        = $clog2(TX_DEPTH) + 1;
    localparam int PW        = CW - 1;
    localparam int RAM_WORDS = (1 << AW) - 4;

    localparam logic [AW-1:0] A_RES   = '1;
    localparam logic [AW-1:0] A_RX    = A_RES - AW'(1);
    localparam logic [AW-1:0] A_ST    = A_RES - AW'(2);
    localparam logic [AW-1:0] A_TX    = A_RES - AW'(3);
    localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

    logic [31:0]   ram_mem  [RAM_WORDS];
    logic [31:0]   fifo_mem [TX_DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] tx_count;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic [31:0]   rx_buf;
    logic [31:0]   status_word;

    logic is_ram;
    logic is_tx;
    logic is_st;
    logic is_rx;
    logic commit;
    logic ram_we;
    logic push;
    logic pop;
    logic rx_load;
    logic rx_pop;

    assign is_ram = (ram_address < A_TX);
    assign is_tx  = (ram_address == A_TX);
    assign is_st  = (ram_address == A_ST);
    assign is_rx  = (ram_address == A_RX);

    // Wrap bit in the pointers distinguishes full from empty.
    assign tx_count = wr_ptr - rd_ptr;
    assign tx_full  = (tx_count == DEPTH_C);
    assign tx_empty = (tx_count == '0);

    // Built only from registered full so tx_ready never reaches the stall.
    assign cpu_stall = ram_enable & ram_read_write & is_tx & tx_full;
    assign commit    = cpu_enable & ram_enable & ~cpu_stall;

    assign ram_we  = commit & ram_read_write & is_ram;
    assign push    = commit & ram_read_write & is_tx;
    assign pop     = tx_valid & tx_ready;
    assign rx_load = rx_valid & ~rx_full;
    assign rx_pop  = commit & ~ram_read_write & is_rx & rx_full;

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr[PW-1:0]] : '0;
    assign rx_ready = ~rx_full;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_address] <= ram_data_write_in;
        end
    end

    // Storage is left unreset; tx_data is gated by tx_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= ram_data_write_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    // Load and pop are mutually exclusive: loading requires the mailbox empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_full <= 1'b0;
            rx_buf  <= '0;
        end else if (rx_load) begin
            rx_full <= 1'b1;
            rx_buf  <= rx_data;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end
    end

    always_comb begin
        status_word         = '0;
        status_word[0]      = tx_full;
        status_word[1]      = tx_empty;
        status_word[2]      = rx_full;
        status_word[8 +: CW] = tx_count;
    end

    always_comb begin
        ram_data_read_out = '0;
        if (ram_enable && !ram_read_write) begin
            if (is_ram) begin
                ram_data_read_out = ram_mem[ram_address];
            end else if (is_st) begin
                ram_data_read_out = status_word;
            end else if (is_rx) begin
                ram_data_read_out = rx_buf;
            end
        end
    end

endmodule
